// File: rtl/carryin_pkg.sv
// Shared codes for the DSP48E1 carry-in sequencer: mux selects, op codes, FSM states.
package carryin_pkg;

  localparam logic [2:0] CINSEL_CARRYIN  = 3'b000;
  localparam logic [2:0] CINSEL_MSB_PCIN = 3'b001;
  localparam logic [2:0] CINSEL_CASCIN   = 3'b010;
  localparam logic [2:0] CINSEL_CASCOUT  = 3'b100;
  localparam logic [2:0] CINSEL_XNOR     = 3'b110;

  localparam logic [1:0] OP_SINGLE = 2'b00;
  localparam logic [1:0] OP_WIDE   = 2'b01;
  localparam logic [1:0] OP_CASC   = 2'b10;
  localparam logic [1:0] OP_ROUND  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_CHAIN = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  // Carry source for word 0 of an operation.
  function automatic logic [2:0] first_sel(input logic [1:0] op);
    case (op)
      OP_CASC:  return CINSEL_CASCIN;
      OP_ROUND: return CINSEL_XNOR;
      default:  return CINSEL_CARRYIN;
    endcase
  endfunction

  // Carry source for words 1..N-1: wide adds chain the slice's own cascade out.
  function automatic logic [2:0] chain_sel(input logic [1:0] op);
    return (op == OP_WIDE) ? CINSEL_CASCOUT : CINSEL_CASCIN;
  endfunction

endpackage

// File: rtl/carryin_word_cnt.sv
// Word sequencing counter: remaining-word down-counter plus issued-word index.
// Holds whenever neither load nor advance is asserted.
module carryin_word_cnt
  import carryin_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] words_i,
  input  logic             adv_i,
  output logic [CNT_W-1:0] idx_nxt_c_o,
  output logic             more_c_o,
  output logic             last_nxt_c_o
);

  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] idx_q;

  // rem_q counts words still to issue after the current one, so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      rem_q <= words_i - CNT_W'(1);
      idx_q <= '0;
    end else if (adv_i && (rem_q != '0)) begin
      rem_q <= rem_q - CNT_W'(1);
      idx_q <= idx_q + CNT_W'(1);
    end
  end

  assign idx_nxt_c_o  = idx_q + CNT_W'(1);
  assign more_c_o     = (rem_q != '0);
  assign last_nxt_c_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/carryin_seq_ctrl.sv
// Carry-in mux sequencer: turns one op request into per-word CARRYINSEL/CARRYIN/CE
// control, drains the carry-in pipeline, and pulses done when the last carry is used.
module carryin_seq_ctrl
  import carryin_pkg::*;
#(
  parameter int unsigned MAX_WORDS   = 16,
  parameter int unsigned CNT_W       = $clog2(MAX_WORDS + 1),
  parameter int unsigned CARRYIN_LAT = 1
) (
  input  logic             clk,
  input  logic             RSTCTRL_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [CNT_W-1:0] req_words,
  input  logic             req_cin,
  input  logic             stall,
  input  logic             abort,
  output logic [2:0]       carryinsel,
  output logic             carryin,
  output logic             CECARRYIN,
  output logic             RSTALLCARRYIN,
  output logic             word_strobe,
  output logic [CNT_W-1:0] word_idx,
  output logic             last_word,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    DRAIN_W = 2;
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WORDS);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               ready_q, ready_d;
  logic [2:0]         sel_q, sel_d;
  logic               cin_q, cin_d;
  logic               ce_q, ce_d;
  logic               rstall_q, rstall_d;
  logic               strobe_q, strobe_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   words_eff_c;
  logic               cnt_load_c, cnt_adv_c;
  logic [CNT_W-1:0]   idx_nxt_c;
  logic               more_c, last_nxt_c;

  carryin_word_cnt #(.CNT_W(CNT_W)) u_word_cnt (
    .clk          (clk),
    .rst_n        (RSTCTRL_n),
    .load_i       (cnt_load_c),
    .words_i      (words_eff_c),
    .adv_i        (cnt_adv_c),
    .idx_nxt_c_o  (idx_nxt_c),
    .more_c_o     (more_c),
    .last_nxt_c_o (last_nxt_c)
  );

  // Single-word ops ignore req_words; zero means one, oversize clamps.
  always_comb begin
    words_eff_c = req_words;
    if ((req_op == OP_SINGLE) || (req_op == OP_ROUND) || (req_words == '0)) begin
      words_eff_c = CNT_W'(1);
    end else if (req_words > MAX_W) begin
      words_eff_c = MAX_W;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    drain_d    = drain_q;
    sel_d      = sel_q;
    cin_d      = cin_q;
    idx_d      = idx_q;
    ready_d    = 1'b0;
    ce_d       = 1'b0;
    rstall_d   = 1'b0;
    strobe_d   = 1'b0;
    last_d     = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    cnt_load_c = 1'b0;
    cnt_adv_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        sel_d   = CINSEL_CARRYIN;
        cin_d   = 1'b0;
        idx_d   = '0;
        if (req_valid && ready_q) begin
          state_d    = ST_FIRST;
          op_d       = req_op;
          cnt_load_c = 1'b1;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          strobe_d   = 1'b1;
          ce_d       = 1'b1;
          last_d     = (words_eff_c == CNT_W'(1));
          sel_d      = first_sel(req_op);
          cin_d      = ((req_op == OP_SINGLE) || (req_op == OP_WIDE)) ? req_cin : 1'b0;
        end
      end

      ST_FIRST, ST_CHAIN: begin
        if (abort) begin
          state_d  = ST_CLEAR;
          rstall_d = 1'b1;
          sel_d    = CINSEL_CARRYIN;
          cin_d    = 1'b0;
          idx_d    = '0;
        end else if (!stall) begin
          if (more_c) begin
            state_d   = ST_CHAIN;
            cnt_adv_c = 1'b1;
            strobe_d  = 1'b1;
            ce_d      = 1'b1;
            idx_d     = idx_nxt_c;
            last_d    = last_nxt_c;
            sel_d     = chain_sel(op_q);
            cin_d     = 1'b0;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_W'(CARRYIN_LAT);
            done_d  = (CARRYIN_LAT == 0);
          end
        end
      end

      // sel/carryin stay put so the in-flight carry is not disturbed.
      ST_DRAIN: begin
        if (abort) begin
          state_d  = ST_CLEAR;
          rstall_d = 1'b1;
          sel_d    = CINSEL_CARRYIN;
          cin_d    = 1'b0;
          idx_d    = '0;
        end else if (drain_q == '0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          sel_d   = CINSEL_CARRYIN;
          cin_d   = 1'b0;
          idx_d   = '0;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
          done_d  = (drain_q == DRAIN_W'(1));
        end
      end

      ST_CLEAR: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTCTRL_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SINGLE;
      drain_q  <= '0;
      ready_q  <= 1'b1;
      sel_q    <= CINSEL_CARRYIN;
      cin_q    <= 1'b0;
      ce_q     <= 1'b0;
      rstall_q <= 1'b0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      drain_q  <= drain_d;
      ready_q  <= ready_d;
      sel_q    <= sel_d;
      cin_q    <= cin_d;
      ce_q     <= ce_d;
      rstall_q <= rstall_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign req_ready     = ready_q;
  assign carryinsel    = sel_q;
  assign carryin       = cin_q;
  assign CECARRYIN     = ce_q;
  assign RSTALLCARRYIN = rstall_q;
  assign word_strobe   = strobe_q;
  assign word_idx      = idx_q;
  assign last_word     = last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_carryin_seq_ctrl.sv
// Self-checking bench for carryin_seq_ctrl: expected per-cycle output traces are built
// from the operation description (word list, stall gaps, drain, abort) and compared cycle by cycle.
module tb_carryin_seq_ctrl;

  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned LAT       = 1;

  typedef struct packed {
    logic [6:0]       flg;   // strobe,last,ce,rstall,done,busy,ready
    logic [2:0]       sel;
    logic             cin;
    logic [CNT_W-1:0] idx;
  } out_t;

  logic             clk;
  logic             RSTCTRL_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [CNT_W-1:0] req_words;
  logic             req_cin;
  logic             stall;
  logic             abort;
  logic [2:0]       carryinsel;
  logic             carryin;
  logic             CECARRYIN;
  logic             RSTALLCARRYIN;
  logic             word_strobe;
  logic [CNT_W-1:0] word_idx;
  logic             last_word;
  logic             busy;
  logic             done;

  carryin_seq_ctrl #(
    .MAX_WORDS   (MAX_WORDS),
    .CNT_W       (CNT_W),
    .CARRYIN_LAT (LAT)
  ) dut (
    .clk           (clk),
    .RSTCTRL_n     (RSTCTRL_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_words     (req_words),
    .req_cin       (req_cin),
    .stall         (stall),
    .abort         (abort),
    .carryinsel    (carryinsel),
    .carryin       (carryin),
    .CECARRYIN     (CECARRYIN),
    .RSTALLCARRYIN (RSTALLCARRYIN),
    .word_strobe   (word_strobe),
    .word_idx      (word_idx),
    .last_word     (last_word),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  out_t exp_q[$];
  out_t obs_q[$];
  bit   chk_q[$];
  bit   stall_q[$];
  bit   abort_q[$];

  function automatic logic [6:0] mk_flg(input logic sb, input logic lw, input logic ce,
                                        input logic rs, input logic dn, input logic by,
                                        input logic rd);
    return {sb, lw, ce, rs, dn, by, rd};
  endfunction

  function automatic out_t sample_out();
    out_t o;
    o.flg = {word_strobe, last_word, CECARRYIN, RSTALLCARRYIN, done, busy, req_ready};
    o.sel = carryinsel;
    o.cin = carryin;
    o.idx = word_idx;
    return o;
  endfunction

  // Expected trace from the cycle after acceptance until the first ready cycle.
  function automatic void build_model(input logic [1:0] op, input int words, input logic cin,
                                      input int st_after, input int st_len, input int ab_at);
    int   n;
    out_t e;
    exp_q.delete(); chk_q.delete(); stall_q.delete(); abort_q.delete();
    e = '0;
    if (op == 2'b00 || op == 2'b11 || words == 0) n = 1;
    else if (words > int'(MAX_WORDS)) n = int'(MAX_WORDS);
    else n = words;
    for (int k = 0; k < n; k++) begin
      e.flg = mk_flg(1'b1, (k == n - 1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k == 0) e.sel = (op == 2'b11) ? 3'b110 : (op == 2'b10) ? 3'b010 : 3'b000;
      else        e.sel = (op == 2'b01) ? 3'b100 : 3'b010;
      e.cin = (k == 0 && (op == 2'b00 || op == 2'b01)) ? cin : 1'b0;
      e.idx = CNT_W'(k);
      exp_q.push_back(e); chk_q.push_back(1'b1);
      stall_q.push_back(k == st_after && st_len > 0); abort_q.push_back(1'b0);
      if (k == st_after) begin
        for (int g = 0; g < st_len; g++) begin
          e.flg = mk_flg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
          exp_q.push_back(e); chk_q.push_back(1'b1);
          stall_q.push_back(g < st_len - 1); abort_q.push_back(1'b0);
        end
      end
    end
    for (int d = 0; d <= int'(LAT); d++) begin
      e.flg = mk_flg(1'b0, 1'b0, 1'b0, 1'b0, (d == int'(LAT)), 1'b1, 1'b0);
      exp_q.push_back(e); chk_q.push_back(1'b1);
      stall_q.push_back(1'($urandom)); abort_q.push_back(1'b0);
    end
    if (ab_at >= 0 && ab_at < exp_q.size()) begin
      while (exp_q.size() > ab_at + 1) begin
        void'(exp_q.pop_back()); void'(chk_q.pop_back());
        void'(stall_q.pop_back()); void'(abort_q.pop_back());
      end
      abort_q[ab_at] = 1'b1;
      e = '0;
      e.flg = mk_flg(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(e); chk_q.push_back(1'b0);
      stall_q.push_back(1'($urandom)); abort_q.push_back(1'($urandom));
    end
    e = '0;
    e.flg = mk_flg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(e); chk_q.push_back(1'b0);
    stall_q.push_back(1'($urandom)); abort_q.push_back(1'($urandom));
  endfunction

  // Issue one request from an idle cycle and record the outputs of every traced cycle.
  task automatic exec_scn(input logic [1:0] op, input int words, input logic cin,
                          input bit keep_valid);
    req_valid = 1'b1;
    req_op    = op;
    req_words = CNT_W'(words);
    req_cin   = cin;
    stall     = 1'($urandom);
    abort     = 1'($urandom);
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      obs_q.push_back(sample_out());
      req_valid = keep_valid && (i != exp_q.size() - 1);
      if (keep_valid) begin
        req_op    = 2'($urandom);
        req_words = CNT_W'($urandom);
        req_cin   = 1'($urandom);
      end
      stall = stall_q[i];
      abort = abort_q[i];
    end
  endtask

  task automatic test_reset();
    out_t o;
    repeat (2) @(posedge clk);
    #1;
    o = sample_out();
    n_cmp++;
    if (o !== out_t'({7'b0000001, 3'b000, 1'b0, CNT_W'(0)})) begin
      n_fail++;
      $display("FAIL reset_values got %h exp %h", o, out_t'({7'b0000001, 3'b000, 1'b0, CNT_W'(0)}));
    end
    RSTCTRL_n = 1'b1;
    @(posedge clk); #1;
    o = sample_out();
    n_cmp++;
    if (o.flg !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_idle flags got %b exp %b", o.flg, 7'b0000001);
    end
  endtask

  task automatic test_single();
    build_model(2'b00, 1, 1'b1, -1, 0, -1);
    exec_scn(2'b00, 1, 1'b1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].flg !== exp_q[i].flg) begin
        n_fail++;
        $display("FAIL single[%0d] flags(sb,lw,ce,rs,dn,by,rd) got %b exp %b", i, obs_q[i].flg, exp_q[i].flg);
      end
      if (chk_q[i]) begin
        n_cmp++;
        if ({obs_q[i].sel, obs_q[i].cin, obs_q[i].idx} !== {exp_q[i].sel, exp_q[i].cin, exp_q[i].idx}) begin
          n_fail++;
          $display("FAIL single[%0d] sel/cin/idx got %0d/%0d/%0d exp %0d/%0d/%0d", i,
                   obs_q[i].sel, obs_q[i].cin, obs_q[i].idx, exp_q[i].sel, exp_q[i].cin, exp_q[i].idx);
        end
      end
    end
  endtask

  task automatic test_wide4();
    build_model(2'b01, 4, 1'b0, -1, 0, -1);
    exec_scn(2'b01, 4, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].flg !== exp_q[i].flg) begin
        n_fail++;
        $display("FAIL wide4[%0d] flags(sb,lw,ce,rs,dn,by,rd) got %b exp %b", i, obs_q[i].flg, exp_q[i].flg);
      end
      if (chk_q[i]) begin
        n_cmp++;
        if ({obs_q[i].sel, obs_q[i].cin, obs_q[i].idx} !== {exp_q[i].sel, exp_q[i].cin, exp_q[i].idx}) begin
          n_fail++;
          $display("FAIL wide4[%0d] sel/cin/idx got %0d/%0d/%0d exp %0d/%0d/%0d", i,
                   obs_q[i].sel, obs_q[i].cin, obs_q[i].idx, exp_q[i].sel, exp_q[i].cin, exp_q[i].idx);
        end
      end
    end
  endtask

  task automatic test_wide_stall();
    build_model(2'b01, 5, 1'b0, 1, 2, -1);
    exec_scn(2'b01, 5, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].flg !== exp_q[i].flg) begin
        n_fail++;
        $display("FAIL wide_stall[%0d] flags(sb,lw,ce,rs,dn,by,rd) got %b exp %b", i, obs_q[i].flg, exp_q[i].flg);
      end
      if (chk_q[i]) begin
        n_cmp++;
        if ({obs_q[i].sel, obs_q[i].cin, obs_q[i].idx} !== {exp_q[i].sel, exp_q[i].cin, exp_q[i].idx}) begin
          n_fail++;
          $display("FAIL wide_stall[%0d] sel/cin/idx got %0d/%0d/%0d exp %0d/%0d/%0d", i,
                   obs_q[i].sel, obs_q[i].cin, obs_q[i].idx, exp_q[i].sel, exp_q[i].cin, exp_q[i].idx);
        end
      end
    end
  endtask

  task automatic test_casc_abort();
    build_model(2'b10, 3, 1'b1, -1, 0, 1);
    exec_scn(2'b10, 3, 1'b1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].flg !== exp_q[i].flg) begin
        n_fail++;
        $display("FAIL casc_abort[%0d] flags(sb,lw,ce,rs,dn,by,rd) got %b exp %b", i, obs_q[i].flg, exp_q[i].flg);
      end
      if (chk_q[i]) begin
        n_cmp++;
        if ({obs_q[i].sel, obs_q[i].cin, obs_q[i].idx} !== {exp_q[i].sel, exp_q[i].cin, exp_q[i].idx}) begin
          n_fail++;
          $display("FAIL casc_abort[%0d] sel/cin/idx got %0d/%0d/%0d exp %0d/%0d/%0d", i,
                   obs_q[i].sel, obs_q[i].cin, obs_q[i].idx, exp_q[i].sel, exp_q[i].cin, exp_q[i].idx);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    logic [1:0] ops[4];
    int         wds[4];
    ops = '{2'b01, 2'b01, 2'b11, 2'b10};
    wds = '{0, int'(MAX_WORDS) + 3, 7, int'(MAX_WORDS)};
    for (int s = 0; s < 4; s++) begin
      build_model(ops[s], wds[s], 1'b1, -1, 0, -1);
      exec_scn(ops[s], wds[s], 1'b1, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i].flg !== exp_q[i].flg) begin
          n_fail++;
          $display("FAIL bound%0d[%0d] flags(sb,lw,ce,rs,dn,by,rd) got %b exp %b", s, i, obs_q[i].flg, exp_q[i].flg);
        end
        if (chk_q[i]) begin
          n_cmp++;
          if ({obs_q[i].sel, obs_q[i].cin, obs_q[i].idx} !== {exp_q[i].sel, exp_q[i].cin, exp_q[i].idx}) begin
            n_fail++;
            $display("FAIL bound%0d[%0d] sel/cin/idx got %0d/%0d/%0d exp %0d/%0d/%0d", s, i,
                     obs_q[i].sel, obs_q[i].cin, obs_q[i].idx, exp_q[i].sel, exp_q[i].cin, exp_q[i].idx);
          end
        end
      end
    end
  endtask

  task automatic test_drain_valid();
    for (int s = 0; s < 2; s++) begin
      build_model((s == 0) ? 2'b00 : 2'b01, 3, 1'b0, -1, 0, -1);
      exec_scn((s == 0) ? 2'b00 : 2'b01, 3, 1'b0, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i].flg !== exp_q[i].flg) begin
          n_fail++;
          $display("FAIL held_valid%0d[%0d] flags(sb,lw,ce,rs,dn,by,rd) got %b exp %b", s, i, obs_q[i].flg, exp_q[i].flg);
        end
        if (chk_q[i]) begin
          n_cmp++;
          if ({obs_q[i].sel, obs_q[i].cin, obs_q[i].idx} !== {exp_q[i].sel, exp_q[i].cin, exp_q[i].idx}) begin
            n_fail++;
            $display("FAIL held_valid%0d[%0d] sel/cin/idx got %0d/%0d/%0d exp %0d/%0d/%0d", s, i,
                     obs_q[i].sel, obs_q[i].cin, obs_q[i].idx, exp_q[i].sel, exp_q[i].cin, exp_q[i].idx);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 3; s++) begin
      build_model(2'(s), 2 + s, 1'b1, -1, 0, -1);
      exec_scn(2'(s), 2 + s, 1'b1, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i].flg !== exp_q[i].flg) begin
          n_fail++;
          $display("FAIL b2b%0d[%0d] flags(sb,lw,ce,rs,dn,by,rd) got %b exp %b", s, i, obs_q[i].flg, exp_q[i].flg);
        end
        if (chk_q[i]) begin
          n_cmp++;
          if ({obs_q[i].sel, obs_q[i].cin, obs_q[i].idx} !== {exp_q[i].sel, exp_q[i].cin, exp_q[i].idx}) begin
            n_fail++;
            $display("FAIL b2b%0d[%0d] sel/cin/idx got %0d/%0d/%0d exp %0d/%0d/%0d", s, i,
                     obs_q[i].sel, obs_q[i].cin, obs_q[i].idx, exp_q[i].sel, exp_q[i].cin, exp_q[i].idx);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    out_t o;
    req_valid = 1'b1; req_op = 2'b01; req_words = CNT_W'(8); req_cin = 1'b0;
    stall = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = sample_out();
    n_cmp++;
    if ({o.flg[6], o.idx} !== {1'b1, CNT_W'(2)}) begin
      n_fail++;
      $display("FAIL midrst_pre strobe/idx got %0d/%0d exp 1/2", o.flg[6], o.idx);
    end
    RSTCTRL_n = 1'b0;
    @(posedge clk); #1;
    o = sample_out();
    n_cmp++;
    if (o !== out_t'({7'b0000001, 3'b000, 1'b0, CNT_W'(0)})) begin
      n_fail++;
      $display("FAIL midrst_values got %h exp %h", o, out_t'({7'b0000001, 3'b000, 1'b0, CNT_W'(0)}));
    end
    RSTCTRL_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      o = sample_out();
      n_cmp++;
      if (o.flg !== 7'b0000001) begin
        n_fail++;
        $display("FAIL midrst_after[%0d] flags got %b exp %b", c, o.flg, 7'b0000001);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    int         wds, st_after, st_len, ab_at;
    logic       cin;
    bit         kv;
    for (int s = 0; s < 40; s++) begin
      op       = 2'($urandom);
      wds      = int'($urandom_range(0, MAX_WORDS + 3));
      cin      = 1'($urandom);
      st_after = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, MAX_WORDS - 1));
      st_len   = int'($urandom_range(1, 3));
      ab_at    = ($urandom_range(0, 2) != 0) ? -1 : int'($urandom_range(0, 24));
      kv       = 1'($urandom);
      build_model(op, wds, cin, st_after, st_len, ab_at);
      exec_scn(op, wds, cin, kv);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i].flg !== exp_q[i].flg) begin
          n_fail++;
          $display("FAIL rnd%0d(op%0d w%0d)[%0d] flags(sb,lw,ce,rs,dn,by,rd) got %b exp %b",
                   s, op, wds, i, obs_q[i].flg, exp_q[i].flg);
        end
        if (chk_q[i]) begin
          n_cmp++;
          if ({obs_q[i].sel, obs_q[i].cin, obs_q[i].idx} !== {exp_q[i].sel, exp_q[i].cin, exp_q[i].idx}) begin
            n_fail++;
            $display("FAIL rnd%0d(op%0d w%0d)[%0d] sel/cin/idx got %0d/%0d/%0d exp %0d/%0d/%0d", s, op, wds, i,
                     obs_q[i].sel, obs_q[i].cin, obs_q[i].idx, exp_q[i].sel, exp_q[i].cin, exp_q[i].idx);
          end
        end
      end
    end
  endtask

  initial begin
    RSTCTRL_n = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_words = '0;
    req_cin   = 1'b0;
    stall     = 1'b0;
    abort     = 1'b0;
    test_reset();
    test_single();
    test_wide4();
    test_wide_stall();
    test_casc_abort();
    test_boundaries();
    test_drain_valid();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
